// File: rtl/fcp_pkg.sv
// fcp_pkg: shared state encoding, header field position and counter widths for the FCP receive path
package fcp_pkg;
  typedef enum logic [1:0] {FCP_ST_IDLE, FCP_ST_PASS, FCP_ST_DROP} fcp_state_e;
  localparam int FCP_CH_LSB = 0;
  localparam int FCP_CH_MSB = 3;
  localparam int FCP_FRAME_W = 16;
  localparam int FCP_DROP_W = 8;
  function automatic logic [FCP_DROP_W-1:0] fcp_drop_sat(input logic [FCP_DROP_W-1:0] c, input logic [1:0] inc);
    logic [FCP_DROP_W:0] s;
    s = {1'b0, c} + (FCP_DROP_W+1)'(inc);
    return s[FCP_DROP_W] ? '1 : s[FCP_DROP_W-1:0];
  endfunction
endpackage

// File: rtl/fcp_rx_portsel_if.sv
// fcp_rx_portsel_if: 8-bit LocalLink stream with sof/eof and src/dst ready
interface fcp_rx_portsel_if;
  logic       sof;
  logic       eof;
  logic       src_rdy;
  logic       dst_rdy;
  logic [7:0] data;
  modport master (output sof, eof, src_rdy, data, input dst_rdy);
  modport slave (input sof, eof, src_rdy, data, output dst_rdy);
endinterface

// File: rtl/fcp_ll_reg.sv
// fcp_ll_reg: single-entry LocalLink output register; holds its byte until the sink takes it
module fcp_ll_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       sof,
  input  logic       eof,
  input  logic [7:0] data,
  output logic       ready,
  fcp_rx_portsel_if.master out
);
  assign ready = !out.src_rdy | out.dst_rdy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out.src_rdy <= 1'b0;
      out.sof     <= 1'b0;
      out.eof     <= 1'b0;
      out.data    <= 8'h00;
    end else if (load) begin
      out.src_rdy <= 1'b1;
      out.sof     <= sof;
      out.eof     <= eof;
      out.data    <= data;
    end else if (out.dst_rdy) begin
      out.src_rdy <= 1'b0;
    end
  end
endmodule

// File: rtl/fcp_rx_portsel.sv
// fcp_rx_portsel: strips the channel header from each upstream frame, selects the channel and forwards the payload
module fcp_rx_portsel
  import fcp_pkg::*;
#(
  parameter logic [15:0] PORT_MASK = 16'hFFFE,
  parameter logic [3:0]  RST_PORT  = 4'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  fcp_rx_portsel_if.slave        rx,
  fcp_rx_portsel_if.master       ch,
  output logic [3:0]             inport_addr,
  output logic [FCP_FRAME_W-1:0] frame_cnt,
  output logic [FCP_DROP_W-1:0]  drop_cnt
);
  fcp_state_e state, nxt;
  logic       first, reg_ready, rdy, acc, hdr, ok_hdr, load, frame_inc;
  logic [1:0] drop_inc;
  logic [3:0] chn;
  assign chn = rx.data[FCP_CH_MSB:FCP_CH_LSB];
  assign rx.dst_rdy = rdy;
  // Any accepted sof byte is a header, even mid-frame; a PASS frame it interrupts counts as a drop too
  always_comb begin
    rdy = (state == FCP_ST_DROP) | reg_ready;
    acc = rx.src_rdy & rdy;
    hdr = acc & rx.sof;
    ok_hdr = hdr & !rx.eof & PORT_MASK[chn];
    load = acc & !rx.sof & (state == FCP_ST_PASS);
    frame_inc = load & rx.eof;
    drop_inc = hdr ? 2'(state == FCP_ST_PASS) + 2'(!ok_hdr) : 2'd0;
    nxt = state;
    if (hdr) nxt = rx.eof ? FCP_ST_IDLE : ok_hdr ? FCP_ST_PASS : FCP_ST_DROP;
    else if (acc & rx.eof & (state != FCP_ST_IDLE)) nxt = FCP_ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FCP_ST_IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inport_addr <= RST_PORT;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      first       <= 1'b0;
    end else begin
      if (ok_hdr) inport_addr <= chn;
      first     <= ok_hdr | (first & !load);
      frame_cnt <= frame_cnt + FCP_FRAME_W'(frame_inc);
      drop_cnt  <= fcp_drop_sat(drop_cnt, drop_inc);
    end
  end
  fcp_ll_reg u_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .sof   (first),
    .eof   (rx.eof),
    .data  (rx.data),
    .ready (reg_ready),
    .out   (ch)
  );
endmodule

// File: tb/tb_fcp_rx_portsel.sv
// tb_fcp_rx_portsel: directed frames with hand-computed deliveries, counters and reset behaviour
module tb_fcp_rx_portsel;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  inport_addr;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  int          pass_n = 0;
  int          total_n = 0;
  logic        force_stall = 1'b0;
  logic        pat_en = 1'b0;
  logic        hold_en = 1'b0;
  logic        held = 1'b0;
  logic [3:0]  pat = 4'b1001;
  int          k = 0;
  int          vld = 0;
  logic        stalled = 1'b0;
  logic [9:0]  prev = '0;
  logic [13:0] q[$];
  logic [31:0] eq[$];

  fcp_rx_portsel_if rx_if ();
  fcp_rx_portsel_if ch_if ();

  fcp_rx_portsel dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx_if),
    .ch          (ch_if),
    .inport_addr (inport_addr),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else pass_n++;
  endtask

  function automatic logic [31:0] e(input logic [3:0] a, input logic s, input logic f, input logic [7:0] d);
    return {18'd0, a, s, f, d};
  endfunction

  task automatic check_q(input string tag);
    chk({tag, "_n"}, 32'(q.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++)
      chk(tag, (i < q.size()) ? 32'(q[i]) : 32'hDEAD, eq[i]);
    q.delete();
    eq.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic f, input logic lat);
    logic ok;
    @(negedge clk);
    rx_if.data = d;
    rx_if.sof = s;
    rx_if.eof = f;
    rx_if.src_rdy = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      #1 ok = rx_if.dst_rdy;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    #1;
    if (lat) chk("latency", {23'd0, ch_if.src_rdy, ch_if.data}, {23'd0, 1'b1, d});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_if.src_rdy = 1'b0;
    rx_if.sof = 1'b0;
    rx_if.eof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sink side: drive in_dst_rdy, then record deliveries and check stall behaviour mid-cycle
  initial begin
    ch_if.dst_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (force_stall) ch_if.dst_rdy = 1'b0;
      else if (hold_en && !held && ch_if.src_rdy && ch_if.data == 8'h22) begin
        ch_if.dst_rdy = 1'b0;
        held = 1'b1;
      end else if (pat_en) begin
        ch_if.dst_rdy = pat[k % 4];
        k++;
      end else ch_if.dst_rdy = 1'b1;
      #1;
      if (rst) stalled = 1'b0;
      else begin
        if (stalled) chk("hold", {21'd0, ch_if.src_rdy, ch_if.sof, ch_if.eof, ch_if.data}, {21'd0, 1'b1, prev});
        if (ch_if.src_rdy && !ch_if.dst_rdy) chk("bp", 32'(rx_if.dst_rdy), 32'd0);
        if (ch_if.src_rdy && ch_if.dst_rdy) q.push_back({inport_addr, ch_if.sof, ch_if.eof, ch_if.data});
        if (ch_if.src_rdy) vld++;
        stalled = ch_if.src_rdy && !ch_if.dst_rdy;
        prev = {ch_if.sof, ch_if.eof, ch_if.data};
      end
    end
  end

  initial begin
    rx_if.sof = 1'b0;
    rx_if.eof = 1'b0;
    rx_if.src_rdy = 1'b0;
    rx_if.data = 8'h00;
    #1;
    chk("rst_vld", 32'(ch_if.src_rdy), 32'd0);
    chk("rst_addr", 32'(inport_addr), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    send(8'h01, 1, 0, 0);
    chk("t1_addr", 32'(inport_addr), 32'd1);
    send(8'hA5, 0, 0, 1);
    send(8'h5A, 0, 0, 1);
    send(8'hC3, 0, 1, 1);
    idle(4);
    eq.push_back(e(4'd1, 1, 0, 8'hA5));
    eq.push_back(e(4'd1, 0, 0, 8'h5A));
    eq.push_back(e(4'd1, 0, 1, 8'hC3));
    check_q("t1");
    chk("t1_frame", 32'(frame_cnt), 32'd1);

    k = 0;
    pat_en = 1'b1;
    send(8'h01, 1, 0, 0);
    send(8'hA5, 0, 0, 0);
    send(8'h5A, 0, 0, 0);
    send(8'hC3, 0, 1, 0);
    idle(6);
    pat_en = 1'b0;
    eq.push_back(e(4'd1, 1, 0, 8'hA5));
    eq.push_back(e(4'd1, 0, 0, 8'h5A));
    eq.push_back(e(4'd1, 0, 1, 8'hC3));
    check_q("t2");
    chk("t2_frame", 32'(frame_cnt), 32'd2);

    hold_en = 1'b1;
    send(8'h02, 1, 0, 0);
    send(8'h11, 0, 0, 0);
    send(8'h22, 0, 1, 0);
    send(8'h01, 1, 0, 0);
    send(8'h33, 0, 1, 0);
    idle(4);
    hold_en = 1'b0;
    eq.push_back(e(4'd2, 1, 0, 8'h11));
    eq.push_back(e(4'd2, 0, 1, 8'h22));
    eq.push_back(e(4'd1, 1, 1, 8'h33));
    check_q("t3");
    chk("t3_frame", 32'(frame_cnt), 32'd4);
    chk("t3_addr", 32'(inport_addr), 32'd1);

    vld = 0;
    send(8'h00, 1, 0, 0);
    send(8'h77, 0, 0, 0);
    send(8'h88, 0, 1, 0);
    idle(3);
    chk("t4_vld", 32'(vld), 32'd0);
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    chk("t4_addr", 32'(inport_addr), 32'd1);
    send(8'h05, 1, 1, 0);
    idle(2);
    chk("t4_drop2", 32'(drop_cnt), 32'd2);
    chk("t4_addr2", 32'(inport_addr), 32'd1);
    check_q("t4");

    send(8'h01, 1, 0, 0);
    send(8'hAA, 0, 0, 0);
    send(8'hBB, 0, 0, 0);
    send(8'hF2, 1, 0, 0);
    chk("t5_addr", 32'(inport_addr), 32'd2);
    chk("t5_drop", 32'(drop_cnt), 32'd3);
    send(8'hCC, 0, 1, 0);
    idle(4);
    eq.push_back(e(4'd1, 1, 0, 8'hAA));
    eq.push_back(e(4'd1, 0, 0, 8'hBB));
    eq.push_back(e(4'd2, 1, 1, 8'hCC));
    check_q("t5");
    chk("t5_frame", 32'(frame_cnt), 32'd5);

    send(8'h03, 1, 0, 0);
    force_stall = 1'b1;
    send(8'h44, 0, 0, 0);
    @(negedge clk);
    chk("t6_pre", 32'(ch_if.src_rdy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_vld", 32'(ch_if.src_rdy), 32'd0);
    chk("t6_out", {22'd0, ch_if.sof, ch_if.eof, ch_if.data}, 32'd0);
    chk("t6_addr", 32'(inport_addr), 32'd0);
    chk("t6_frame", 32'(frame_cnt), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    force_stall = 1'b0;
    q.delete();
    send(8'h04, 1, 0, 0);
    send(8'h66, 0, 1, 0);
    idle(4);
    eq.push_back(e(4'd4, 1, 1, 8'h66));
    check_q("t6");
    chk("t6_frame2", 32'(frame_cnt), 32'd1);
    chk("t6_addr2", 32'(inport_addr), 32'd4);

    repeat (254) send(8'h09, 1, 1, 0);
    idle(1);
    chk("t7_drop_fe", 32'(drop_cnt), 32'hFE);
    repeat (6) send(8'h09, 1, 1, 0);
    idle(1);
    chk("t7_drop_sat", 32'(drop_cnt), 32'hFF);
    chk("t7_frame", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
